irq_ctrl: RTL and testbench
===========================

# irq_ctrl

Interrupt source block sitting directly upstream of the core's `interrupt` input. It synchronizes and latches external interrupt requests, adds a machine timer source (mtime/mtimecmp), and selects one pending enabled source by fixed priority. It holds a single-level `interrupt` line to the core until the core acknowledges it. Software configures it through a small register port.

## Interface
- NUM_SRC, 4, number of external interrupt lines (1..16)
- TIMER_W, 32, width of mtime/mtimecmp
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- ext_irq  in  NUM_SRC  asynchronous external requests
- cfg_we  in  1  register write strobe
- cfg_addr  in  3  register select
- cfg_wdata  in  32  write data
- cfg_rdata  out  32  read data, combinational from cfg_addr
- interrupt  out  1  registered request to core
- irq_id  out  5  registered source id; valid while interrupt=1
- irq_ack  in  1  core has taken the trap; sampled only while interrupt=1

## Operation
- Register map (addr): 0 ENABLE[NUM_SRC:0], 1 EDGE[NUM_SRC-1:0] (1=rising-edge, 0=level), 2 PENDING (read; write-1-to-clear, edge bits only), 3 MTIME, 4 MTIMECMP; others read 0, writes ignored.
- Source ids: externals 0..NUM_SRC-1, timer = NUM_SRC; timer has highest priority, then lowest external index.
- ext_irq passes a 2-flop synchronizer; edge detect compares sync output with its previous value.
- Edge source pending bit: set on a detected rising edge, cleared by ack of that id or a W1C write. Level source pending = synchronized level, not latched. Timer pending = (MTIME >= MTIMECMP) unsigned; cleared only by rewriting MTIMECMP/MTIME.
- MTIME increments by 1 every cycle, wraps 2^TIMER_W-1 -> 0.
- FSM: IDLE: if any (PENDING & ENABLE), latch winning id into irq_id, interrupt<=1, -> ASSERT. ASSERT: hold interrupt and irq_id regardless of ENABLE/PENDING changes; on irq_ack clear edge pending for irq_id, interrupt<=0, -> GAP. GAP: one cycle, interrupt=0, -> IDLE.
- Simultaneous: set and clear (ack or W1C) of same pending bit in one cycle -> set wins. MTIME write and increment same cycle -> written value wins. irq_ack while not ASSERT ignored.
- Reset: interrupt=0, irq_id=0, ENABLE=0, EDGE=0, PENDING=0, synchronizer/edge flops=0, MTIME=0, MTIMECMP=all-ones, FSM=IDLE. Reset mid-ASSERT drops interrupt on the next edge; the pending request is lost.

## Timing
- ext_irq rising before edge k: sync stage 2 high at edge k+1, pending set at edge k+2, interrupt=1 after edge k+3 (3-cycle visible latency from first sampling edge).
- Timer: MTIME reaching MTIMECMP at edge t -> interrupt=1 after edge t+1.
- irq_ack high at edge a -> interrupt=0 after edge a; earliest re-assert after edge a+2 (GAP).
- Config write at edge w takes effect for edge w+1 evaluation; cfg_rdata reflects current register state, zero latency.

## Structure
- Package irq_pkg: register address constants, FSM state enum (IDLE, ASSERT, GAP), TIMER_ID derivation helper.
- Sub-module irq_sync (2-flop synchronizer plus edge detector, vector width parameter); the rest stays in irq_ctrl.

## Test plan
- After reset: interrupt=0, irq_id=0, cfg_rdata at addr 4 = 0xFFFFFFFF; ext_irq[2] pulsed with ENABLE=0 -> no interrupt, PENDING[2]=1 (edge mode).
- ENABLE=0x2, EDGE=0x2, ext_irq[1] rises before edge k -> interrupt=1, irq_id=1 after edge k+3; ack at edge a -> interrupt=0 after a, PENDING[1]=0.
- ext_irq[0] and ext_irq[3] edge simultaneously, ENABLE=0x9 -> irq_id=0 first; after ack + GAP, irq_id=3.
- MTIMECMP=MTIME+10, ENABLE bit NUM_SRC set -> interrupt with irq_id=4 ~11 cycles later; rewrite MTIMECMP larger -> no re-assert after ack.
- New edge on source 1 in same cycle as ack of id 1 -> PENDING[1] stays 1, interrupt re-asserts 2 cycles after ack.
- rst asserted while interrupt=1 -> interrupt=0 and all registers at reset values after next edge; MTIME write of 0xFFFFFFFF then wraps to 0 one cycle later.

Source files
------------

// File: rtl/irq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_pkg
// Description : Shared constants, FSM state encoding and helpers for the
//               interrupt source controller.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_pkg;

    // Width of the source id presented to the core
    localparam int ID_W = 5;

    // Register map
    localparam logic [2:0] ADDR_ENABLE   = 3'd0;
    localparam logic [2:0] ADDR_EDGE     = 3'd1;
    localparam logic [2:0] ADDR_PENDING  = 3'd2;
    localparam logic [2:0] ADDR_MTIME    = 3'd3;
    localparam logic [2:0] ADDR_MTIMECMP = 3'd4;

    // Request handshake state towards the core
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ASSERT = 2'd1,
        ST_GAP    = 2'd2
    } irq_state_e;

    // The timer sits directly above the last external line
    function automatic logic [ID_W-1:0] timer_id(input int num_src);
        return ID_W'(num_src);
    endfunction

endpackage : irq_pkg
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Two-flop synchronizer for asynchronous request lines plus a
//               rising-edge detector on the synchronized value.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] async_i,
    output logic [WIDTH-1:0] level_o,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;

    // Synchronizer chain plus one extra stage holding the previous level
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= async_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign level_o = sync_q;
    assign rise_o  = sync_q & ~prev_q;

endmodule : irq_sync
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt source controller. Latches/synchronizes external
//               requests, adds an mtime/mtimecmp timer source, picks one
//               pending enabled source by fixed priority and holds a single
//               interrupt line to the core until acknowledged.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int TIMER_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_SRC-1:0]  ext_irq_i,
    input  logic                cfg_we_i,
    input  logic [2:0]          cfg_addr_i,
    input  logic [31:0]         cfg_wdata_i,
    output logic [31:0]         cfg_rdata_o,
    output logic                interrupt_o,
    output logic [4:0]          irq_id_o,
    input  logic                irq_ack_i
);

    localparam logic [ID_W-1:0] TIMER_ID = timer_id(NUM_SRC);

    // Configuration and timer state
    logic [NUM_SRC:0]   enable_q,   enable_d;
    logic [NUM_SRC-1:0] edge_q,     edge_d;
    logic [TIMER_W-1:0] mtime_q,    mtime_d;
    logic [TIMER_W-1:0] mtimecmp_q, mtimecmp_d;

    // Latched edge-mode pending bits (level-mode bits stay zero here)
    logic [NUM_SRC-1:0] pend_q, pend_d;

    // Handshake FSM and registered outputs
    irq_state_e         state_q, state_d;
    logic               irq_q,   irq_d;
    logic [ID_W-1:0]    id_q,    id_d;

    // Combinational helpers
    logic [NUM_SRC-1:0] sync_level;
    logic [NUM_SRC-1:0] sync_rise;
    logic [NUM_SRC-1:0] ext_pend;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] w1c_clr;
    logic [NUM_SRC:0]   pend_all;
    logic [NUM_SRC:0]   active;
    logic               timer_pend;
    logic               ack_fire;
    logic               wr_enable;
    logic               wr_edge;
    logic               wr_pending;
    logic               wr_mtime;
    logic               wr_mtimecmp;
    logic [ID_W-1:0]    win_id;

    irq_sync #(
        .WIDTH   (NUM_SRC)
    ) u_sync (
        .clk     (clk),
        .rst     (rst),
        .async_i (ext_irq_i),
        .level_o (sync_level),
        .rise_o  (sync_rise)
    );

    assign wr_enable   = cfg_we_i && (cfg_addr_i == ADDR_ENABLE);
    assign wr_edge     = cfg_we_i && (cfg_addr_i == ADDR_EDGE);
    assign wr_pending  = cfg_we_i && (cfg_addr_i == ADDR_PENDING);
    assign wr_mtime    = cfg_we_i && (cfg_addr_i == ADDR_MTIME);
    assign wr_mtimecmp = cfg_we_i && (cfg_addr_i == ADDR_MTIMECMP);

    // An acknowledge only counts while the request is actually being held
    assign ack_fire    = (state_q == ST_ASSERT) && irq_ack_i;

    assign timer_pend  = (mtime_q >= mtimecmp_q);
    assign pend_all    = {timer_pend, ext_pend};
    assign active      = pend_all & enable_q;

    // Per-source pending: a new edge beats any clear arriving in the same cycle
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            assign ack_clr[gi]  = ack_fire && (id_q == ID_W'(gi));
            assign w1c_clr[gi]  = wr_pending && cfg_wdata_i[gi];
            assign pend_d[gi]   = edge_q[gi] &
                                  ((pend_q[gi] & ~(ack_clr[gi] | w1c_clr[gi]))
                                   | sync_rise[gi]);
            assign ext_pend[gi] = edge_q[gi] ? pend_q[gi] : sync_level[gi];
        end
    endgenerate

    // Fixed priority: timer first, then the lowest external index
    always_comb begin
        win_id = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (active[i]) begin
                win_id = ID_W'(i);
            end
        end
        if (active[NUM_SRC]) begin
            win_id = TIMER_ID;
        end
    end

    // Next-state for configuration registers and the free-running timer
    always_comb begin
        enable_d   = enable_q;
        edge_d     = edge_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q + TIMER_W'(1);
        if (wr_enable) begin
            enable_d = cfg_wdata_i[NUM_SRC:0];
        end
        if (wr_edge) begin
            edge_d = cfg_wdata_i[NUM_SRC-1:0];
        end
        if (wr_mtime) begin
            mtime_d = TIMER_W'(cfg_wdata_i);
        end
        if (wr_mtimecmp) begin
            mtimecmp_d = TIMER_W'(cfg_wdata_i);
        end
    end

    // Configuration, timer and pending registers
    always_ff @(posedge clk) begin
        if (rst) begin
            enable_q   <= '0;
            edge_q     <= '0;
            pend_q     <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            enable_q   <= enable_d;
            edge_q     <= edge_d;
            pend_q     <= pend_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    // Handshake next-state: latch a winner, hold until ack, then one idle gap
    always_comb begin
        state_d = state_q;
        irq_d   = irq_q;
        id_d    = id_q;
        case (state_q)
            ST_IDLE: begin
                if (|active) begin
                    id_d    = win_id;
                    irq_d   = 1'b1;
                    state_d = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (irq_ack_i) begin
                    irq_d   = 1'b0;
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                irq_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Handshake state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            irq_q   <= 1'b0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            irq_q   <= irq_d;
            id_q    <= id_d;
        end
    end

    // Zero-latency register readback
    always_comb begin
        cfg_rdata_o = '0;
        case (cfg_addr_i)
            ADDR_ENABLE:   cfg_rdata_o = 32'(enable_q);
            ADDR_EDGE:     cfg_rdata_o = 32'(edge_q);
            ADDR_PENDING:  cfg_rdata_o = 32'(pend_all);
            ADDR_MTIME:    cfg_rdata_o = 32'(mtime_q);
            ADDR_MTIMECMP: cfg_rdata_o = 32'(mtimecmp_q);
            default:       cfg_rdata_o = '0;
        endcase
    end

    assign interrupt_o = irq_q;
    assign irq_id_o    = id_q;

endmodule : irq_ctrl
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed self-checking bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  ext_irq;
    logic        cfg_we;
    logic [2:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        interrupt;
    logic [4:0]  irq_id;
    logic        irq_ack;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    irq_ctrl #(
        .NUM_SRC     (4),
        .TIMER_W     (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ext_irq_i   (ext_irq),
        .cfg_we_i    (cfg_we),
        .cfg_addr_i  (cfg_addr),
        .cfg_wdata_i (cfg_wdata),
        .cfg_rdata_o (cfg_rdata),
        .interrupt_o (interrupt),
        .irq_id_o    (irq_id),
        .irq_ack_i   (irq_ack)
    );

    // Write lands on the posedge between this negedge and the next
    task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_we = 1'b0; cfg_wdata = '0;
    endtask

    task automatic cfg_read(input logic [2:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_rdata;
    endtask

    task automatic ack_pulse();
        irq_ack = 1'b1;
        @(negedge clk);
        irq_ack = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst = 1'b1; ext_irq = '0; cfg_we = 1'b0; cfg_addr = '0;
        cfg_wdata = '0; irq_ack = 1'b0;
        cycles(3);
        rst = 1'b0;
        if (interrupt !== 1'b0) begin $display("FAIL reset_int: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        if (irq_id !== 5'd0) begin $display("FAIL reset_id: got %0d want 0", irq_id); n_err++; end
        n_cmp++;
        cfg_read(3'd3, rd);
        if (rd !== 32'h0) begin $display("FAIL reset_mtime: got %h want 0", rd); n_err++; end
        n_cmp++;
        cfg_read(3'd4, rd);
        if (rd !== 32'hFFFF_FFFF) begin $display("FAIL reset_mtimecmp: got %h want ffffffff", rd); n_err++; end
        n_cmp++;
        // Edge mode on source 2 with nothing enabled: latches, no request
        cfg_write(3'd1, 32'h4);
        ext_irq[2] = 1'b1;
        @(negedge clk);
        ext_irq[2] = 1'b0;
        cycles(3);
        if (interrupt !== 1'b0) begin $display("FAIL disabled_int: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        cfg_read(3'd2, rd);
        if (rd !== 32'h4) begin $display("FAIL disabled_pend: got %h want 4", rd); n_err++; end
        n_cmp++;
        cfg_write(3'd2, 32'h4);
        cfg_read(3'd2, rd);
        if (rd !== 32'h0) begin $display("FAIL w1c_pend: got %h want 0", rd); n_err++; end
        n_cmp++;
    endtask

    task automatic test_edge_irq();
        logic [31:0] rd;
        cfg_write(3'd1, 32'h2);
        cfg_write(3'd0, 32'h2);
        ext_irq[1] = 1'b1;
        cycles(3);
        if (interrupt !== 1'b0) begin $display("FAIL edge_early: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        cfg_read(3'd2, rd);
        if (rd !== 32'h2) begin $display("FAIL edge_pend: got %h want 2", rd); n_err++; end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b1 || irq_id !== 5'd1) begin
            $display("FAIL edge_assert: got int=%0b id=%0d want int=1 id=1", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        ack_pulse();
        if (interrupt !== 1'b0) begin $display("FAIL edge_ack_int: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        cfg_read(3'd2, rd);
        if (rd !== 32'h0) begin $display("FAIL edge_ack_pend: got %h want 0", rd); n_err++; end
        n_cmp++;
        cycles(2);
        if (interrupt !== 1'b0) begin $display("FAIL edge_no_reassert: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        ext_irq[1] = 1'b0;
        cycles(3);
    endtask

    task automatic test_priority();
        logic [31:0] rd;
        cfg_write(3'd1, 32'h9);
        cfg_write(3'd0, 32'h9);
        ext_irq[0] = 1'b1; ext_irq[3] = 1'b1;
        cycles(4);
        if (interrupt !== 1'b1 || irq_id !== 5'd0) begin
            $display("FAIL prio_first: got int=%0b id=%0d want int=1 id=0", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        cfg_read(3'd2, rd);
        if (rd !== 32'h9) begin $display("FAIL prio_pend: got %h want 9", rd); n_err++; end
        n_cmp++;
        ack_pulse();
        cfg_read(3'd2, rd);
        if (rd !== 32'h8) begin $display("FAIL prio_pend_after_ack: got %h want 8", rd); n_err++; end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b0) begin $display("FAIL prio_gap: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b1 || irq_id !== 5'd3) begin
            $display("FAIL prio_second: got int=%0b id=%0d want int=1 id=3", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        ack_pulse();
        cfg_read(3'd2, rd);
        if (interrupt !== 1'b0 || rd !== 32'h0) begin
            $display("FAIL prio_done: got int=%0b pend=%h want int=0 pend=0", interrupt, rd); n_err++;
        end
        n_cmp++;
        ext_irq = '0;
        cycles(3);
    endtask

    task automatic test_timer();
        logic [31:0] rd;
        cfg_write(3'd0, 32'h0);
        cfg_write(3'd3, 32'd100);
        cfg_read(3'd3, rd);
        if (rd !== 32'd100) begin $display("FAIL mtime_write: got %0d want 100", rd); n_err++; end
        n_cmp++;
        cfg_write(3'd4, 32'd110);
        cfg_write(3'd0, 32'h10);
        cycles(7);
        cfg_read(3'd2, rd);
        if (rd !== 32'h0) begin $display("FAIL timer_below: got %h want 0", rd); n_err++; end
        n_cmp++;
        cycles(1);
        cfg_read(3'd2, rd);
        if (rd !== 32'h10 || interrupt !== 1'b0) begin
            $display("FAIL timer_equal: got pend=%h int=%0b want pend=10 int=0", rd, interrupt); n_err++;
        end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b1 || irq_id !== 5'd4) begin
            $display("FAIL timer_assert: got int=%0b id=%0d want int=1 id=4", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        cfg_write(3'd4, 32'hFFFF_0000);
        if (interrupt !== 1'b1 || irq_id !== 5'd4) begin
            $display("FAIL timer_hold: got int=%0b id=%0d want int=1 id=4", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        ack_pulse();
        cycles(3);
        cfg_read(3'd2, rd);
        if (interrupt !== 1'b0 || rd !== 32'h0) begin
            $display("FAIL timer_cleared: got int=%0b pend=%h want int=0 pend=0", interrupt, rd); n_err++;
        end
        n_cmp++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        cfg_write(3'd1, 32'h2);
        cfg_write(3'd0, 32'h2);
        ext_irq[1] = 1'b1;
        cycles(2);
        ext_irq[1] = 1'b0;
        cycles(1);
        ext_irq[1] = 1'b1;
        cycles(1);
        if (interrupt !== 1'b1 || irq_id !== 5'd1) begin
            $display("FAIL race_first: got int=%0b id=%0d want int=1 id=1", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        cycles(1);
        ack_pulse();
        cfg_read(3'd2, rd);
        if (interrupt !== 1'b0 || rd !== 32'h2) begin
            $display("FAIL race_set_wins: got int=%0b pend=%h want int=0 pend=2", interrupt, rd); n_err++;
        end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b0) begin $display("FAIL race_gap: got %0b want 0", interrupt); n_err++; end
        n_cmp++;
        cycles(1);
        if (interrupt !== 1'b1 || irq_id !== 5'd1) begin
            $display("FAIL race_reassert: got int=%0b id=%0d want int=1 id=1", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        ack_pulse();
        ext_irq[1] = 1'b0;
        cycles(3);
    endtask

    task automatic test_reset_mid_assert();
        logic [31:0] rd;
        logic [31:0] rd2;
        cfg_write(3'd4, 32'h1234_0000);
        ext_irq[1] = 1'b1;
        cycles(4);
        if (interrupt !== 1'b1) begin $display("FAIL pre_reset_int: got %0b want 1", interrupt); n_err++; end
        n_cmp++;
        rst = 1'b1; ext_irq = '0;
        cycles(1);
        if (interrupt !== 1'b0 || irq_id !== 5'd0) begin
            $display("FAIL mid_reset_out: got int=%0b id=%0d want int=0 id=0", interrupt, irq_id); n_err++;
        end
        n_cmp++;
        cfg_read(3'd0, rd);
        cfg_read(3'd1, rd2);
        if (rd !== 32'h0 || rd2 !== 32'h0) begin
            $display("FAIL mid_reset_cfg: got en=%h edge=%h want 0 0", rd, rd2); n_err++;
        end
        n_cmp++;
        cycles(1);
        cfg_read(3'd2, rd);
        cfg_read(3'd4, rd2);
        if (rd !== 32'h0 || rd2 !== 32'hFFFF_FFFF) begin
            $display("FAIL mid_reset_pend_cmp: got pend=%h cmp=%h want 0 ffffffff", rd, rd2); n_err++;
        end
        n_cmp++;
        rst = 1'b0;
        cfg_write(3'd3, 32'hFFFF_FFFF);
        cfg_read(3'd3, rd);
        cfg_read(3'd2, rd2);
        if (rd !== 32'hFFFF_FFFF || rd2 !== 32'h10) begin
            $display("FAIL mtime_max: got mtime=%h pend=%h want ffffffff 10", rd, rd2); n_err++;
        end
        n_cmp++;
        cycles(1);
        cfg_read(3'd3, rd);
        cfg_read(3'd2, rd2);
        if (rd !== 32'h0 || rd2 !== 32'h0 || interrupt !== 1'b0) begin
            $display("FAIL mtime_wrap: got mtime=%h pend=%h int=%0b want 0 0 0", rd, rd2, interrupt); n_err++;
        end
        n_cmp++;
    endtask

    initial begin
        test_reset();
        test_edge_irq();
        test_priority();
        test_timer();
        test_back_to_back();
        test_reset_mid_assert();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_irq_ctrl
`default_nettype wire
